// File: rtl/kd_tree_ctrl.sv
// Root-port sequencer for the kd-tree: resets the tree, streams the initial centers from a
// valid/ready source, then configures the sort axis, with a per-phase watchdog and cycle profiler.
module kd_tree_ctrl #(
  parameter int DATA_W      = 24,
  parameter int CMD_W       = 5,
  parameter int MAX_CENTERS = 10,
  parameter int CNT_W       = $clog2(MAX_CENTERS + 1),
  parameter int TIMEOUT     = 1024,
  parameter int CYC_W       = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_centers,
  input  logic [DATA_W-1:0] center_data,
  input  logic              center_valid,
  output logic              center_ready,
  output logic [CMD_W-1:0]  cmd_to_root,
  output logic [DATA_W-1:0] data_to_root,
  input  logic [CMD_W-1:0]  cmd_from_root,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  fill_count,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(5'b00000);
  localparam logic [CMD_W-1:0] CMD_RST       = CMD_W'(5'b11111);
  localparam logic [CMD_W-1:0] CMD_RST_DONE  = CMD_W'(5'b11110);
  localparam logic [CMD_W-1:0] CMD_FILL      = CMD_W'(5'b00001);
  localparam logic [CMD_W-1:0] CMD_AXIS      = CMD_W'(5'b00010);
  localparam logic [CMD_W-1:0] CMD_FILL_DONE = CMD_W'(5'b00101);
  localparam logic [CMD_W-1:0] CMD_AXIS_DONE = CMD_W'(5'b00111);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_AXIS = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_EARLY   = 2'd2;
  localparam logic [1:0] ERR_COUNT   = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CENTERS);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]       state, state_nxt;
  logic [1:0]       code_nxt;
  logic [CNT_W-1:0] num_lat;
  logic [WD_W-1:0]  wd_cnt;
  logic             accept, count_ok, handshake, fill_fire, wd_expired, waiting;

  assign center_ready = (state == S_FILL) && (fill_count < num_lat);
  assign handshake    = center_ready && center_valid;
  assign wd_expired   = (wd_cnt == WD_LAST);
  assign waiting      = (state == S_RST) || (state == S_FILL) || (state == S_AXIS);
  assign count_ok     = (num_centers != '0) && (num_centers <= MAX_CNT);
  assign accept       = start && !waiting;
  // A word that arrives on the same edge as an abort is not forwarded to the root.
  assign fill_fire    = handshake && (state_nxt == S_FILL);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    code_nxt  = err_code;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (count_ok) begin
            state_nxt = S_RST;
            code_nxt  = ERR_NONE;
          end else begin
            state_nxt = S_ERR;
            code_nxt  = ERR_COUNT;
          end
        end
      end
      S_RST: begin
        if (cmd_from_root == CMD_RST_DONE) begin
          state_nxt = S_FILL;
        end else if (wd_expired) begin
          state_nxt = S_ERR;
          code_nxt  = ERR_TIMEOUT;
        end
      end
      S_FILL: begin
        if (cmd_from_root == CMD_FILL_DONE) begin
          if (fill_count < num_lat) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_EARLY;
          end else begin
            state_nxt = S_AXIS;
          end
        end else if (!handshake && wd_expired) begin
          state_nxt = S_ERR;
          code_nxt  = ERR_TIMEOUT;
        end
      end
      S_AXIS: begin
        if (cmd_from_root == CMD_AXIS_DONE) begin
          state_nxt = S_DONE;
        end else if (wd_expired) begin
          state_nxt = S_ERR;
          code_nxt  = ERR_TIMEOUT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cmd_to_root  <= CMD_NOP;
      data_to_root <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      fill_count   <= '0;
      cycle_count  <= '0;
      num_lat      <= '0;
      wd_cnt       <= '0;
    end else begin
      state    <= state_nxt;
      err_code <= code_nxt;
      busy     <= (state_nxt == S_RST) || (state_nxt == S_FILL) || (state_nxt == S_AXIS);
      done     <= (state_nxt == S_DONE);
      error    <= (state_nxt == S_ERR);

      // The command register tracks the state being entered, so it is aligned with it.
      case (state_nxt)
        S_RST:   cmd_to_root <= CMD_RST;
        S_AXIS:  cmd_to_root <= CMD_AXIS;
        S_FILL:  cmd_to_root <= fill_fire ? CMD_FILL : CMD_NOP;
        default: cmd_to_root <= CMD_NOP;
      endcase

      if (fill_fire) data_to_root <= center_data;

      if (accept)         fill_count <= '0;
      else if (fill_fire) fill_count <= fill_count + CNT_W'(1);

      if (accept)                            cycle_count <= '0;
      else if (busy && (cycle_count != '1))  cycle_count <= cycle_count + CYC_W'(1);

      if (accept && count_ok) num_lat <= num_centers;

      // Watchdog measures time since the last sign of progress in a wait phase.
      if (!waiting || (state_nxt != state) || fill_fire) wd_cnt <= '0;
      else                                               wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Bench for kd_tree_ctrl: a behavioural root/source model drives each scenario from a table
// and from random draws, and every cycle's outputs are compared against phase-level predictions.
module tb_kd_tree_ctrl;

  localparam int DATA_W     = 24;
  localparam int CMD_W      = 5;
  localparam int MAX_C      = 10;
  localparam int CNT_W      = 4;
  localparam int CYC_W      = 27;
  localparam int TB_TIMEOUT = 16;
  localparam int BUDGET     = 400;

  localparam logic [CMD_W-1:0] NOP       = 5'b00000;
  localparam logic [CMD_W-1:0] RST       = 5'b11111;
  localparam logic [CMD_W-1:0] RST_DONE  = 5'b11110;
  localparam logic [CMD_W-1:0] FILL      = 5'b00001;
  localparam logic [CMD_W-1:0] AXIS      = 5'b00010;
  localparam logic [CMD_W-1:0] FILL_DONE = 5'b00101;
  localparam logic [CMD_W-1:0] AXIS_DONE = 5'b00111;
  localparam logic [CMD_W-1:0] BUSY_CMD  = 5'b01000;

  typedef enum int {P_IDLE, P_RST, P_FILL, P_AXIS, P_DONE, P_ERR} phase_t;

  typedef struct {
    int n;          // num_centers requested
    int gap;        // source idle cycles after each word
    int d_rst;      // root latency for rst_done (-1 = never)
    int d_fill;     // root latency for center_fill_done after trigger word (-1 = never)
    int d_axis;     // root latency for configure_sort_axis_done (-1 = never)
    int early;      // send center_fill_done after this many words (-1 = after all)
    int rst_after;  // pulse reset once this many words are loaded (-1 = never)
    bit noise;      // drive unrelated root commands and stray start pulses
    bit exp_done;
    bit exp_error;
    int exp_code;
    int exp_fc;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset, start, center_valid, center_ready;
  logic [CNT_W-1:0]  num_centers;
  logic [DATA_W-1:0] center_data, data_to_root;
  logic [CMD_W-1:0]  cmd_to_root, cmd_from_root;
  logic              busy, done, error;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  fill_count;
  logic [CYC_W-1:0]  cycle_count;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] tb_data;

  kd_tree_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_centers  (num_centers),
    .center_data  (center_data),
    .center_valid (center_valid),
    .center_ready (center_ready),
    .cmd_to_root  (cmd_to_root),
    .data_to_root (data_to_root),
    .cmd_from_root(cmd_from_root),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .fill_count   (fill_count),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d,
                                        input logic r, input logic b, input logic dn,
                                        input logic e, input logic [1:0] ec,
                                        input logic [CNT_W-1:0] fc, input logic [CYC_W-1:0] cc);
    return 128'({c, d, r, b, dn, e, ec, fc, cc});
  endfunction

  function automatic logic [127:0] pack_dut();
    return pack(cmd_to_root, data_to_root, center_ready, busy, done, error, err_code,
                fill_count, cycle_count);
  endfunction

  // Root chatter that must never be mistaken for the acknowledgement of the current phase.
  function automatic logic [CMD_W-1:0] noise_cmd(input phase_t p);
    logic [CMD_W-1:0] c;
    case ($urandom_range(4))
      0:       c = NOP;
      1:       c = BUSY_CMD;
      2:       c = RST_DONE;
      3:       c = FILL_DONE;
      default: c = AXIS_DONE;
    endcase
    if ((p == P_RST && c == RST_DONE) || (p == P_FILL && c == FILL_DONE) ||
        (p == P_AXIS && c == AXIS_DONE))
      c = NOP;
    return c;
  endfunction

  task automatic run_seq(input vec_t v, input string tag);
    logic [DATA_W-1:0] words [MAX_C];
    phase_t            phase;
    logic [CMD_W-1:0]  exp_cmd;
    logic [1:0]        code;
    int  fc, cc, pc, idx, stall, t_rst, t_fill, t_axis, hold, trig;
    bit  fired_prev, rst_pulse, fill_pulse, axis_pulse, exp_ready, exp_busy, fire, do_reset;
    bit  finished;

    foreach (words[i]) words[i] = DATA_W'($urandom);
    fc = 0; cc = 0; pc = 0; idx = 0; stall = 0; hold = 2; finished = 0;
    t_rst = -1; t_fill = -1; t_axis = -1; fired_prev = 0;
    trig = (v.early >= 0) ? v.early : v.n;

    @(negedge clk);
    start = 1'b1; num_centers = CNT_W'(v.n); center_valid = 1'b0; cmd_from_root = NOP;
    if (v.n == 0 || v.n > MAX_C) begin
      phase = P_ERR; code = 2'd3;
    end else begin
      phase = P_RST; code = 2'd0;
    end

    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = 1'b0; center_valid = 1'b0; cmd_from_root = NOP; reset = 1'b1;

      exp_busy  = (phase == P_RST) || (phase == P_FILL) || (phase == P_AXIS);
      exp_ready = (phase == P_FILL) && (fc < v.n);
      exp_cmd   = (phase == P_RST) ? RST : (phase == P_AXIS) ? AXIS :
                  (phase == P_FILL && fired_prev) ? FILL : NOP;
      check($sformatf("%s k=%0d", tag, k), pack_dut(),
            pack(exp_cmd, tb_data, exp_ready, exp_busy, phase == P_DONE, phase == P_ERR,
                 code, CNT_W'(fc), CYC_W'(cc)));

      if (!exp_busy) begin
        if (hold == 0) begin
          finished = 1;
          break;
        end
        hold--;
        continue;
      end

      // Root latencies count from the first cycle the root could see the relevant command.
      if (phase == P_RST && t_rst < 0 && v.d_rst >= 0) t_rst = k + v.d_rst;
      if (phase == P_FILL && fired_prev && fc == trig && t_fill < 0 && v.d_fill >= 0)
        t_fill = k + v.d_fill;
      if (phase == P_AXIS && t_axis < 0 && v.d_axis >= 0) t_axis = k + v.d_axis;

      rst_pulse  = (phase == P_RST)  && (k == t_rst);
      fill_pulse = (phase == P_FILL) && (k == t_fill);
      axis_pulse = (phase == P_AXIS) && (k == t_axis);
      if (rst_pulse)       cmd_from_root = RST_DONE;
      else if (fill_pulse) cmd_from_root = FILL_DONE;
      else if (axis_pulse) cmd_from_root = AXIS_DONE;
      else if (v.noise)    cmd_from_root = noise_cmd(phase);

      center_valid = (stall == 0) && (idx < v.n);
      if (center_valid) center_data = words[idx];
      else              center_data = DATA_W'($urandom);

      if (v.noise) begin
        start       = ($urandom_range(3) == 0);
        num_centers = CNT_W'($urandom);
      end

      do_reset = (v.rst_after >= 0) && (phase == P_FILL) && (fc == v.rst_after);
      if (do_reset) begin
        reset = 1'b0;
        phase = P_IDLE; fc = 0; cc = 0; code = 2'd0; tb_data = '0; fired_prev = 0;
        continue;
      end

      fire = (phase == P_FILL) && !fill_pulse && exp_ready && center_valid;
      cc++;
      fired_prev = 0;
      case (phase)
        P_RST: begin
          if (rst_pulse) begin
            phase = P_FILL; pc = 0;
          end else begin
            pc++;
            if (pc == TB_TIMEOUT) begin phase = P_ERR; code = 2'd1; end
          end
        end
        P_FILL: begin
          if (fill_pulse) begin
            if (fc < v.n) begin
              phase = P_ERR; code = 2'd2;
            end else begin
              phase = P_AXIS; pc = 0;
            end
          end else if (fire) begin
            tb_data = words[idx];
            fc++; idx++; fired_prev = 1; pc = 0; stall = v.gap;
          end else begin
            if (stall > 0) stall--;
            pc++;
            if (pc == TB_TIMEOUT) begin phase = P_ERR; code = 2'd1; end
          end
        end
        P_AXIS: begin
          if (axis_pulse) begin
            phase = P_DONE;
          end else begin
            pc++;
            if (pc == TB_TIMEOUT) begin phase = P_ERR; code = 2'd1; end
          end
        end
        default: ;
      endcase
    end

    check({tag, " finished"}, 128'(finished), 128'(1));
    check({tag, " final"}, 128'({done, error, err_code, fill_count}),
          128'({v.exp_done, v.exp_error, 2'(v.exp_code), CNT_W'(v.exp_fc)}));
  endtask

  initial begin
    vec_t tbl [14];
    vec_t v;

    reset = 1'b0; start = 1'b0; num_centers = '0; center_data = '0; center_valid = 1'b0;
    cmd_from_root = NOP; tb_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", pack_dut(), pack(NOP, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0));
    reset = 1'b1;

    //         n  gap rst fil axs erl rsa nz  done err code fc
    tbl[0]  = '{3,  0,  2,  1,  4, -1, -1, 0,  1,  0,  0,  3};  // nominal
    tbl[1]  = '{3,  5,  2,  1,  4, -1, -1, 0,  1,  0,  0,  3};  // source stalls
    tbl[2]  = '{3,  0, -1,  1,  4, -1, -1, 0,  0,  1,  1,  0};  // rst_done never
    tbl[3]  = '{3,  5,  2,  1,  4,  1, -1, 0,  0,  1,  2,  1};  // early fill_done
    tbl[4]  = '{0,  0,  2,  1,  4, -1, -1, 0,  0,  1,  3,  0};  // num_centers 0
    tbl[5]  = '{11, 0,  2,  1,  4, -1, -1, 0,  0,  1,  3,  0};  // num_centers 11
    tbl[6]  = '{3,  1,  2,  1,  4, -1,  2, 0,  0,  0,  0,  0};  // reset mid-fill
    tbl[7]  = '{3,  0,  2,  1,  4, -1, -1, 1,  1,  0,  0,  3};  // restart with noise
    tbl[8]  = '{10, 0,  1,  2,  1, -1, -1, 1,  1,  0,  0, 10};  // max count
    tbl[9]  = '{1,  0,  0,  0,  0, -1, -1, 0,  1,  0,  0,  1};  // single word, instant root
    tbl[10] = '{2, 20,  2,  1,  4, -1, -1, 0,  0,  1,  1,  1};  // source stall timeout
    tbl[11] = '{2,  0,  2,  1, -1, -1, -1, 0,  0,  1,  1,  2};  // axis_done never
    tbl[12] = '{2,  0, 15,  1,  4, -1, -1, 0,  1,  0,  0,  2};  // rst_done on last legal cycle
    tbl[13] = '{2,  0, 16,  1,  4, -1, -1, 0,  0,  1,  1,  0};  // rst_done one cycle late

    foreach (tbl[i]) run_seq(tbl[i], $sformatf("tbl%0d", i));

    for (int r = 0; r < 10; r++) begin
      v.n      = $urandom_range(1, MAX_C);
      v.gap    = $urandom_range(0, 6);
      v.d_rst  = $urandom_range(0, 8);
      v.d_fill = $urandom_range(0, 8);
      v.d_axis = $urandom_range(0, 8);
      v.early = -1; v.rst_after = -1; v.noise = 1;
      v.exp_done = 1; v.exp_error = 0; v.exp_code = 0; v.exp_fc = v.n;
      run_seq(v, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
